// File: rtl/arb_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_defs (package)
//  Description : Shared definitions for the round-robin grant controller:
//                arbiter state encoding and requester-count derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_defs;

  // Arbiter states: IDLE arbitrates, BUSY holds the current owner.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Number of requesters served for a given index width.
  function automatic int n_req(input int data_size);
    return 1 << data_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab19_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lab19_encoder
//  Description : One-hot to binary encoder with a non-zero flag. An all-zero
//                input encodes to index 0 with flag_valid low.
//  Revision    : 1.0 - initial release
// ============================================================================
module lab19_encoder
  import arb_defs::*;
#(
  parameter int DATA_SIZE = 2,
  localparam int N_IN = n_req(DATA_SIZE)
) (
  input  logic [N_IN-1:0]      data_i,
  output logic [DATA_SIZE-1:0] code_o,
  output logic                 flag_valid
);

  // OR together the indices of all set bits; exact for one-hot input.
  always_comb begin
    code_o = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (data_i[k]) code_o = code_o | DATA_SIZE'(k);
    end
  end

  assign flag_valid = |data_i;

endmodule
`default_nettype wire

// File: rtl/rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_ctrl
//  Description : Round-robin arbiter sharing one resource among 2**DATA_SIZE
//                requesters. A grant is held until the owner drops its
//                request or MAX_HOLD cycles elapse; a timed-out requester is
//                masked until it drops and re-raises its request.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_ctrl
  import arb_defs::*;
#(
  parameter int DATA_SIZE = 2,
  parameter int MAX_HOLD  = 16,
  localparam int N_REQ    = n_req(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     grant,
  output logic [DATA_SIZE-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 timeout
);

  localparam int HW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     mask_q, mask_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;
  logic [DATA_SIZE-1:0] ptr_q, ptr_d;
  logic [DATA_SIZE-1:0] owner_q, owner_d;
  logic [HW-1:0]        hold_q, hold_d;

  logic [N_REQ-1:0]     eligible;
  logic [DATA_SIZE:0]   pick_res;
  logic                 found;
  logic [DATA_SIZE-1:0] winner;
  logic                 enc_valid;

  // First eligible index searching start, start+1, ... (wraps naturally
  // because N_REQ is a power of two). Returns {found, index}.
  function automatic logic [DATA_SIZE:0] rr_pick(input logic [N_REQ-1:0]     elig,
                                                 input logic [DATA_SIZE-1:0] start);
    logic [DATA_SIZE:0]   res;
    logic [DATA_SIZE-1:0] idx;
    res = '0;
    // Walk from the farthest offset down so the nearest hit wins last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start + DATA_SIZE'(i);
      if (elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign eligible = req & ~mask_q;
  assign pick_res = rr_pick(eligible, ptr_q);
  assign found    = pick_res[DATA_SIZE];
  assign winner   = pick_res[DATA_SIZE-1:0];

  // Next-state and output decode; every target defaults to holding.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    mask_d    = mask_q & req;   // a dropped request always clears its mask
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = N_REQ'(1) << winner;
          valid_d = 1'b1;
          hold_d  = HW'(1);
          ptr_d   = winner + DATA_SIZE'(1);
          owner_d = winner;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req[owner_q]) begin
          // Release has priority over a coincident timeout.
          grant_d = '0;
          valid_d = 1'b0;
          hold_d  = '0;
          state_d = ST_IDLE;
        end else if ((MAX_HOLD != 0) && (hold_q == MAX_HOLD_C)) begin
          grant_d         = '0;
          valid_d         = 1'b0;
          hold_d          = '0;
          timeout_d       = 1'b1;
          mask_d[owner_q] = 1'b1;
          state_d         = ST_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      mask_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
    end
  end

  // Binary index for the downstream mux select, decoded from the grant flops.
  lab19_encoder #(
    .DATA_SIZE (DATA_SIZE)
  ) u_enc (
    .data_i     (grant_q),
    .code_o     (grant_idx),
    .flag_valid (enc_valid)
  );

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

  // The valid flop must always agree with the decoded grant vector.
  a_valid_consistent: assert property (@(posedge clk) disable iff (!rst_n)
                                       valid_q == enc_valid);

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_grant_ctrl
//  Description : Scoreboard bench for rr_grant_ctrl (DATA_SIZE=2, MAX_HOLD=4)
//                with directed scenarios and random request traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_ctrl;

  localparam int DS = 2;
  localparam int NR = 4;
  localparam int MH = 4;

  typedef struct packed {
    logic [NR-1:0] g;
    logic [DS-1:0] i;
    logic          v;
    logic          t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] grant;
  logic [DS-1:0] grant_idx;
  logic          grant_valid;
  logic          timeout;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  // Reference model state: owner -1 means nobody holds the resource.
  int        m_owner = -1;
  int        m_hold  = 0;
  int        m_ptr   = 0;
  bit [NR-1:0] m_mask = '0;

  rr_grant_ctrl #(
    .DATA_SIZE (DS),
    .MAX_HOLD  (MH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
    m_mask  = '0;
  endtask

  // Advance the model by one clock edge with request vector r and push the
  // outputs expected after that edge.
  task automatic model_step(input logic [NR-1:0] r);
    bit [NR-1:0] nmask;
    bit          tout;
    bit          hit;
    int          c;
    exp_t        e;
    nmask = m_mask & r;
    tout  = 1'b0;
    if (m_owner < 0) begin
      hit = 1'b0;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (!hit && r[c] && !m_mask[c]) begin
          hit     = 1'b1;
          m_owner = c;
          m_hold  = 1;
          m_ptr   = (c + 1) % NR;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
      m_hold  = 0;
    end else if (m_hold == MH) begin
      nmask[m_owner] = 1'b1;
      m_owner = -1;
      m_hold  = 0;
      tout    = 1'b1;
    end else begin
      m_hold++;
    end
    m_mask = nmask;
    e.g = (m_owner >= 0) ? NR'(1) << m_owner : '0;
    e.i = (m_owner >= 0) ? DS'(m_owner) : '0;
    e.v = (m_owner >= 0);
    e.t = tout;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [NR-1:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
  endtask

  // Monitor: after every active edge, retire one expected entry.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{g: grant, i: grant_idx, v: grant_valid, t: timeout};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
                   $time, a.g, a.i, a.v, a.t, e.g, e.i, e.v, e.t);
        end
      end
    end
  end

  task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  initial begin
    logic [NR-1:0] r;
    int            wait_cnt;

    // Reset state straight out of power-up reset.
    repeat (2) @(negedge clk);
    check_now("reset_grant", 8'(grant), 8'h0);
    check_now("reset_valid", 8'({grant_idx, grant_valid, timeout}), 8'h0);

    // Release reset and request from 2: grant one edge later.
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0100;
    model_step(4'b0100);
    repeat (4) drive(4'b0100);
    repeat (3) drive(4'b0000);

    // Reset asserted mid-grant clears outputs without a clock edge.
    drive(4'b0100);
    drive(4'b0100);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_grant", 8'(grant), 8'h0);
    check_now("async_idx_valid_to", 8'({grant_idx, grant_valid, timeout}), 8'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_step(req);
    drive(4'b0000);
    drive(4'b0000);

    // Fairness: all requesting, each owner releases after two grant cycles.
    for (int n = 0; n < 20; n++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_hold >= 2) r[m_owner] = 1'b0;
      drive(r);
    end
    drive(4'b0000);

    // Wrap: end a grant to requester 3, then offer 0 and 3 together.
    drive(4'b1000);
    drive(4'b1000);
    drive(4'b0000);
    drive(4'b1001);
    drive(4'b1001);
    drive(4'b0000);

    // Timeout: requester 1 stuck, requester 3 waiting.
    while (m_ptr != 1) begin
      drive(4'b0001);
      drive(4'b0000);
    end
    repeat (16) drive(4'b1010);
    drive(4'b0000);
    drive(4'b0010);
    drive(4'b0010);
    drive(4'b0000);

    // Release coinciding with the hold limit counts as a release.
    drive(4'b0010);
    for (int n = 0; n < 8 && m_owner >= 0; n++) begin
      drive((m_hold == MH) ? 4'b0000 : 4'b0010);
    end
    drive(4'b0010);
    drive(4'b0010);
    drive(4'b0000);

    // Random request traffic.
    r = '0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
      end
      drive(r);
    end
    drive(4'b0000);

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (sb_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter and grant controller that shares one resource among 2**DATA_SIZE requesters. It holds each grant until the owner releases it or a hold timeout expires. It drives a registered one-hot grant vector plus its binary index and a valid flag. It sits in front of the shared datapath, and downstream logic uses grant_idx as the mux select.

## Interface
- DATA_SIZE, 2: log2 of requester count; N_REQ = 2**DATA_SIZE (default 4).
- MAX_HOLD, 16: max consecutive cycles one owner may hold the grant; 0 disables the timeout.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous and active-low.
- req  input  N_REQ  request per requester; level, held high for the whole ownership.
- grant  output  N_REQ  registered one-hot grant; all-zero when idle.
- grant_idx  output  DATA_SIZE  binary index of the set grant bit; 0 when idle.
- grant_valid  output  1  high iff grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, BUSY. Internal registers: ptr (DATA_SIZE bits), hold_cnt ($clog2(MAX_HOLD+1) bits, minimum 1), mask (N_REQ bits), owner.
- Reset values: state IDLE, grant 0, grant_idx 0, grant_valid 0, timeout 0, ptr 0, hold_cnt 0, mask 0.
- IDLE:
  - eligible = req & ~mask.
  - If eligible is non-zero, the winner is the first set bit searching ptr, ptr+1, … mod N_REQ.
  - Next edge: grant = one-hot(winner), grant_valid = 1, hold_cnt = 1, ptr = (winner+1) mod N_REQ, state BUSY.
- BUSY, in priority order:
  1. req[owner] = 0: next edge grant = 0, valid = 0, hold_cnt = 0, state IDLE.
  2. MAX_HOLD != 0 and hold_cnt == MAX_HOLD: next edge grant = 0, valid = 0, timeout = 1, mask[owner] = 1, state IDLE.
  3. Otherwise: hold_cnt += 1. The grant is unchanged.
- mask[k] clears on any edge where req[k] = 0. A timed-out requester is not re-granted until it drops and re-raises req.
- Other requesters' req changes during BUSY have no effect on the current grant.
- timeout is high for exactly one cycle and is never asserted together with grant_valid.
- Invariant: grant has at most one bit set, and grant_idx is consistent with grant at all times.

## Timing
- All outputs are registered. There is no combinational path from req to any output.
- Request to grant in IDLE: 1 cycle.
- Release (req[owner] falls) to grant low: 1 cycle.
- Handover: at least one IDLE cycle between consecutive grants. Fully loaded throughput is one grant per (hold + 2) cycles.
- Timeout: the grant is high for exactly MAX_HOLD cycles, then drops together with the timeout pulse.
- Simultaneous release and timeout in the same cycle: treated as a release. timeout stays 0 and mask is not set.
- Wrap-around: ptr goes from N_REQ-1 to 0.
- rst_n asserted mid-grant: all outputs and registers return to reset values immediately, without waiting for clk. The first arbitration happens on the first rising edge after deassertion.

## Structure
- Shared package/header arb_defs: state encodings (ST_IDLE, ST_BUSY) and the N_REQ derivation.
- One sub-module: grant_idx is produced by instantiating the team's one-hot-to-binary encoder (lab19_encoder, DATA_SIZE passed through) on the registered grant. grant_valid is cross-checked against the encoder's flag_valid.
- Rotating-priority search is a function or generate loop inside this module; no further sub-modules.

## Test plan
- Reset: assert rst_n low while grant = 0100 -> grant, grant_idx, valid and timeout read 0 before the next clk edge; first grant appears one edge after release.
- Single requester: req = 0100 at cycle 0 -> grant = 0100, idx = 2, valid = 1 after edge 1; req drops at cycle 5 -> grant = 0 after edge 6.
- Fairness: req = 1111, each owner releases after 2 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
- Wrap: after a grant to requester 3 ends, apply req = 1001 -> next grant is 0001.
- Timeout, MAX_HOLD = 4: req[1] stuck high and req[3] high -> 0010 held 4 cycles, then a 1-cycle timeout pulse, then 1000. Requester 1 is not re-granted until req[1] toggles low.
- Simultaneous, MAX_HOLD = 4: owner drops req in the cycle hold_cnt = 4 -> grant clears, timeout stays 0, and the owner stays eligible.
